// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray encode/decode and default address width.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;

  // Functions work on a fixed wide vector; callers zero-extend narrower
  // pointers, which leaves both conversions exact for the low bits.
  localparam int GRAY_MAX_W = 16;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into the R_CLK domain.
// Latency: STAGES R_CLK edges from d to q.
// Backpressure: none; samples every cycle.
// Ports: R_CLK clock, RST async active-low reset, d async input, q synchronised output.
module sync_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             R_CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge R_CLK or negedge RST) begin
    if (!RST) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: read pointer, empty/almost-empty, fill level, underflow.
// Latency: read reflected next cycle; remote writes visible after SYNC_STAGES+1 edges.
// Backpressure: reads refused while EMPTY_flag is set; such requests raise sticky UNDERFLOW.
// Ports: R_CLK/RST clock and async active-low reset; Rinc read request; wptr_gray remote
//        write pointer; clr_underflow clears UNDERFLOW; read_addr, rptr_gray, EMPTY_flag,
//        AEMPTY_flag, rd_level, UNDERFLOW are all registered outputs.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = FIFO_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic              R_CLK,
  input  logic              RST,
  input  logic              Rinc,
  input  logic [ADDR_W:0]   wptr_gray,
  input  logic              clr_underflow,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              EMPTY_flag,
  output logic              AEMPTY_flag,
  output logic [ADDR_W:0]   rd_level,
  output logic              UNDERFLOW
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wq;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic          rd_en;
  logic          empty_next;
  logic          aempty_next;
  logic          underflow_next;

  sync_nff #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_wptr_sync (
    .R_CLK(R_CLK),
    .RST  (RST),
    .d    (wptr_gray),
    .q    (wq)
  );

  always_comb begin
    rd_en      = Rinc & ~EMPTY_flag;
    rbin_next  = rbin + PW'(rd_en);
    rgray_next = PW'(bin2gray(GRAY_MAX_W'(rbin_next)));
    wbin       = PW'(gray2bin(GRAY_MAX_W'(wq)));
    // Flags look at the post-read pointer so a read shows up next cycle,
    // while wq lags the writer, keeping empty/level pessimistic.
    level_next     = wbin - rbin_next;
    empty_next     = (rgray_next == wq);
    aempty_next    = (int'(level_next) <= AEMPTY_TH);
    // A fresh underflow outranks a clear in the same cycle.
    underflow_next = (Rinc & EMPTY_flag) | (UNDERFLOW & ~clr_underflow);
  end

  always_ff @(posedge R_CLK or negedge RST) begin
    if (!RST) begin
      rbin        <= '0;
      rptr_gray   <= '0;
      rd_level    <= '0;
      UNDERFLOW   <= 1'b0;
      EMPTY_flag  <= 1'b1;
      AEMPTY_flag <= 1'b1;
    end else begin
      rbin        <= rbin_next;
      rptr_gray   <= rgray_next;
      rd_level    <= level_next;
      UNDERFLOW   <= underflow_next;
      EMPTY_flag  <= empty_next;
      AEMPTY_flag <= aempty_next;
    end
  end

  // Low bits of the binary pointer register; the extra MSB only marks the lap.
  assign read_addr = rbin[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic       R_CLK;
  logic       RST;
  logic       Rinc;
  logic [4:0] wptr_gray;
  logic       clr_underflow;
  logic [3:0] read_addr;
  logic [4:0] rptr_gray;
  logic       EMPTY_flag;
  logic       AEMPTY_flag;
  logic [4:0] rd_level;
  logic       UNDERFLOW;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(
    .ADDR_W     (4),
    .SYNC_STAGES(2),
    .AEMPTY_TH  (2)
  ) dut (
    .R_CLK        (R_CLK),
    .RST          (RST),
    .Rinc         (Rinc),
    .wptr_gray    (wptr_gray),
    .clr_underflow(clr_underflow),
    .read_addr    (read_addr),
    .rptr_gray    (rptr_gray),
    .EMPTY_flag   (EMPTY_flag),
    .AEMPTY_flag  (AEMPTY_flag),
    .rd_level     (rd_level),
    .UNDERFLOW    (UNDERFLOW)
  );

  initial R_CLK = 1'b0;
  always #5 R_CLK = ~R_CLK;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge R_CLK);
    #1;
  endtask

  // Hand-computed values for five reads from a level of 5.
  logic [4:0] exp_gray  [5] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111};
  logic [4:0] exp_level [5] = '{5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
  logic       exp_ae    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       exp_empty [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [4:0] exp_rbin;
  logic [4:0] prev_gray;
  int         abs_cnt;

  initial begin
    RST           = 1'b0;
    Rinc          = 1'b0;
    wptr_gray     = 5'b00000;
    clr_underflow = 1'b0;
    #7;
    check("rst_empty",  32'(EMPTY_flag),  32'd1);
    check("rst_aempty", 32'(AEMPTY_flag), 32'd1);
    check("rst_addr",   32'(read_addr),   32'd0);
    check("rst_rgray",  32'(rptr_gray),   32'd0);
    check("rst_level",  32'(rd_level),    32'd0);
    check("rst_uflow",  32'(UNDERFLOW),   32'd0);
    #5;
    RST = 1'b1;
    tick();
    check("idle_empty",  32'(EMPTY_flag),  32'd1);
    check("idle_aempty", 32'(AEMPTY_flag), 32'd1);
    check("idle_level",  32'(rd_level),    32'd0);

    // Writer publishes Gray(5); visible only after three edges.
    wptr_gray = 5'b00111;
    tick();
    tick();
    check("lag_empty", 32'(EMPTY_flag), 32'd1);
    tick();
    check("fill_empty",  32'(EMPTY_flag),  32'd0);
    check("fill_level",  32'(rd_level),    32'd5);
    check("fill_aempty", 32'(AEMPTY_flag), 32'd0);

    Rinc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rd_addr",   32'(read_addr),   32'(k + 1));
      check("rd_rgray",  32'(rptr_gray),   32'(exp_gray[k]));
      check("rd_level",  32'(rd_level),    32'(exp_level[k]));
      check("rd_aempty", 32'(AEMPTY_flag), 32'(exp_ae[k]));
      check("rd_empty",  32'(EMPTY_flag),  32'(exp_empty[k]));
    end

    // Keep requesting while empty.
    tick();
    check("uf_addr",  32'(read_addr), 32'd5);
    check("uf_rgray", 32'(rptr_gray), 32'b00111);
    check("uf_set",   32'(UNDERFLOW), 32'd1);
    Rinc = 1'b0;
    tick();
    tick();
    check("uf_sticky", 32'(UNDERFLOW), 32'd1);
    clr_underflow = 1'b1;
    tick();
    check("uf_clr", 32'(UNDERFLOW), 32'd0);
    Rinc = 1'b1;
    tick();
    check("uf_wins",      32'(UNDERFLOW), 32'd1);
    check("uf_wins_addr", 32'(read_addr), 32'd5);
    Rinc = 1'b0;
    tick();
    check("uf_clr2", 32'(UNDERFLOW), 32'd0);
    clr_underflow = 1'b0;

    // Streaming: writer stays a full FIFO ahead of the reader.
    exp_rbin  = 5'd5;
    wptr_gray = g5(5'(exp_rbin + 5'd16));
    tick();
    tick();
    tick();
    check("st_empty", 32'(EMPTY_flag), 32'd0);
    check("st_level", 32'(rd_level),   32'd16);
    prev_gray = rptr_gray;
    Rinc      = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_rbin = exp_rbin + 5'd1;
      abs_cnt  = 5 + i + 1;
      check("st_addr",  32'(read_addr), 32'(exp_rbin[3:0]));
      check("st_rgray", 32'(rptr_gray), 32'(g5(exp_rbin)));
      check("st_ham1",  32'($countones(prev_gray ^ rptr_gray)), 32'd1);
      check("st_empty", 32'(EMPTY_flag), 32'd0);
      if (abs_cnt == 16) begin
        check("wrap16_addr", 32'(read_addr),    32'd0);
        check("wrap16_msb",  32'(rptr_gray[4]), 32'd1);
      end
      if (abs_cnt == 32) begin
        check("wrap32_addr", 32'(read_addr),    32'd0);
        check("wrap32_msb",  32'(rptr_gray[4]), 32'd0);
      end
      prev_gray = rptr_gray;
      wptr_gray = g5(5'(exp_rbin + 5'd16));
    end

    // Asynchronous reset between clock edges, reads still in flight.
    @(posedge R_CLK);
    #3;
    RST = 1'b0;
    #1;
    check("arst_empty",  32'(EMPTY_flag),  32'd1);
    check("arst_aempty", 32'(AEMPTY_flag), 32'd1);
    check("arst_addr",   32'(read_addr),   32'd0);
    check("arst_rgray",  32'(rptr_gray),   32'd0);
    check("arst_level",  32'(rd_level),    32'd0);
    check("arst_uflow",  32'(UNDERFLOW),   32'd0);
    Rinc = 1'b0;
    #10;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
